pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-side counterpart of the 19-bit CPU control decoder: fetches
//  instruction words and presents op/funct/target to the decoder. Consumes the
//  decoder's jump/push/pop outputs to choose the next PC.
//  Holds the PC, instruction register and return-address stack. Sits between
//  instruction memory and the control decoder.
// PARAMETERS
//  XLEN         19  instruction, PC and return-address width (bits)
//  STACK_DEPTH  8   return-address stack entries (power of 2, >=2)
//  RESET_PC     0   PC value after reset and after a stack underflow
// PORTS
//  clk              in   1     single clock, rising edge
//  rst              in   1     asynchronous, active-high reset
//  imem_req         out  1     fetch request; held until imem_valid
//  imem_addr        out  XLEN  fetch address (= pc while imem_req=1)
//  imem_rdata       in   XLEN  instruction word; sampled when imem_valid=1
//  imem_valid       in   1     memory response strobe; any latency >=1 cycle
//  op               out  5     ir[18:14], to decoder
//  funct            out  5     ir[4:0], to decoder
//  target           out  XLEN  {5'b0, ir[13:0]}, jump/call destination
//  instr_valid      out  1     op/funct/target valid; decoder outputs sampled
//  jump             in   2     from decoder: 00 seq, 01 target, 11 return, 10 = 00
//  push             in   1     from decoder: push return address (call)
//  pop              in   1     from decoder: pop return address (return)
//  pc               out  XLEN  address of the instruction in ir
//  stack_overflow   out  1     sticky: push while stack full
//  stack_underflow  out  1     sticky: pop/jump=11 while stack empty
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, sp=0.
//   All outputs 0 except pc and imem_addr, which are RESET_PC. Stack contents
//   are don't-care.
//  FSM (3 states):
//   IDLE  -> FETCH unconditionally (first cycle after rst deasserts).
//   FETCH  imem_req=1, imem_addr=pc. Stays in FETCH while imem_valid=0.
//          On imem_valid=1: ir<=imem_rdata, then go to EXEC.
//   EXEC   instr_valid=1 for exactly 1 cycle. jump/push/pop are sampled this
//          cycle (decoder is combinational). pc<=next_pc, then go to FETCH.
//  Throughput: 1 instruction per (memory latency + 1) cycles. Zero-wait memory
//   (imem_valid in the first FETCH cycle) gives 2 cycles/instruction.
//  next_pc, in priority order:
//   jump=11 (or pop) and sp>0   : stack[sp-1]; sp<=sp-1.
//   jump=11 (or pop) and sp==0  : RESET_PC; set stack_underflow; sp unchanged.
//   jump=01                     : target.
//   otherwise                   : pc+1, modulo 2^XLEN (wraps 7FFFF->00000).
//  push (evaluated in EXEC alongside jump):
//   Pushes pc+1 (mod 2^XLEN) and increments sp.
//   If sp==STACK_DEPTH: no write, sp unchanged, set stack_overflow. The jump
//   is still taken.
//  push and pop both high: pop wins, push ignored, no flag set.
//  Sticky flags clear only on rst.
//  imem_valid outside FETCH is ignored.
//  imem_rdata is used only in the cycle imem_valid=1.
//  op/funct/target hold their ir-derived values outside EXEC; only
//   instr_valid qualifies them.
//  Reset during FETCH drops imem_req in the same cycle. A late imem_valid is
//   ignored (state IDLE).
// TESTING
//  1. Zero-wait mem, ir=0x08000 (op 00010) at pc 0 -> instr_valid pulses every
//     2nd cycle; pc 0,1,2,3; op=5'b00010.
//  2. imem_valid delayed 3 cycles -> imem_req high 4 cycles, addr stable, one
//     instr_valid pulse, ir = word on the valid cycle.
//  3. pc=0x00010, jump=01 with push, target=0x00100 -> pc=0x00100, stack
//     top=0x00011. Later jump=11 + pop -> pc=0x00011, sp back to 0.
//  4. 9 nested calls (STACK_DEPTH=8) -> 9th sets stack_overflow, sp=8, jump
//     taken. 8 returns restore in LIFO order. 9th return -> pc=RESET_PC,
//     stack_underflow=1.
//  5. pc=0x7FFFF, jump=00 -> pc=0x00000. jump=10 behaves as 00.
//  6. rst asserted mid-FETCH, then imem_valid next cycle -> imem_req=0, pc=0,
//     ir unchanged (0), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-side sequencer: fetches words from instruction memory, presents
// op/funct/target to the control decoder and picks the next PC from its reply.
module pc_sequencer #(
  parameter int              XLEN        = 19,
  parameter int              STACK_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [4:0]      op,
  output logic [4:0]      funct,
  output logic [XLEN-1:0] target,
  output logic            instr_valid,
  input  logic [1:0]      jump,
  input  logic            push,
  input  logic            pop,
  output logic [XLEN-1:0] pc,
  output logic            stack_overflow,
  output logic            stack_underflow
);

  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [XLEN-1:0] stack_q [STACK_DEPTH];

  logic            push_en;
  logic            ret;
  logic [XLEN-1:0] pc_inc;
  logic [SPW-2:0]  wr_idx;
  logic [SPW-2:0]  rd_idx;

  assign ret    = (jump == 2'b11) || pop;
  assign pc_inc = pc_q + 1'b1;
  assign wr_idx = sp_q[SPW-2:0];
  assign rd_idx = sp_q[SPW-2:0] - 1'b1;

  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign op              = ir_q[XLEN-1 -: 5];
  assign funct           = ir_q[4:0];
  assign target          = {{(XLEN-14){1'b0}}, ir_q[13:0]};
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    sp_d        = sp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_en     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        state_d     = S_FETCH;
        // A return (jump=11 or pop) outranks everything, including a push.
        if (ret) begin
          if (sp_q != '0) begin
            pc_d = stack_q[rd_idx];
            sp_d = sp_q - 1'b1;
          end else begin
            pc_d  = RESET_PC;
            unf_d = 1'b1;
          end
        end else begin
          pc_d = (jump == 2'b01) ? target : pc_inc;
          if (push) begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench for pc_sequencer: a queue-based reference model predicts
// PC, return stack and sticky flags for each fetched/executed instruction.
module tb_pc_sequencer;

  localparam int          XLEN    = 19;
  localparam int          DEPTH   = 8;
  localparam logic [18:0] RST_PC  = 19'h00000;
  localparam logic [18:0] RST_PCW = 19'h7FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [1:0]  jump = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;

  logic        imem_req, instr_valid, stack_overflow, stack_underflow;
  logic [18:0] imem_addr, target, pc;
  logic [4:0]  op, funct;

  logic        w_imem_req, w_instr_valid, w_ovf, w_unf;
  logic [18:0] w_imem_addr, w_target, w_pc;
  logic [4:0]  w_op, w_funct;

  pc_sequencer #(.XLEN(XLEN), .STACK_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .op(op), .funct(funct),
    .target(target), .instr_valid(instr_valid), .jump(jump), .push(push),
    .pop(pop), .pc(pc), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow));

  // Second instance whose reset PC sits just below the wrap point.
  pc_sequencer #(.XLEN(XLEN), .STACK_DEPTH(DEPTH), .RESET_PC(RST_PCW)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .op(w_op),
    .funct(w_funct), .target(w_target), .instr_valid(w_instr_valid),
    .jump(jump), .push(push), .pop(pop), .pc(w_pc), .stack_overflow(w_ovf),
    .stack_underflow(w_unf));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] mpc;
  logic [18:0] stk[$];
  logic        movf, munf;

  logic        obs_iv, obs_iv_after, obs_req_after, obs_addr_ok;
  logic [4:0]  obs_op, obs_funct;
  logic [18:0] obs_target, obs_pc_exec, obs_pc_next, obs_w_pc_next;
  int          obs_req_cnt;

  task automatic model_reset();
    mpc  = RST_PC;
    stk.delete();
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic model_step(input logic [18:0] word, input logic [1:0] j,
                            input logic p, input logic o);
    logic [18:0] old;
    old = mpc;
    if (j == 2'b11 || o) begin
      if (stk.size() > 0) mpc = stk.pop_back();
      else begin
        mpc  = RST_PC;
        munf = 1'b1;
      end
    end else begin
      mpc = (j == 2'b01) ? {5'b0, word[13:0]} : old + 19'd1;
      if (p) begin
        if (stk.size() == DEPTH) movf = 1'b1;
        else stk.push_back(old + 19'd1);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    jump = '0; push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Entered #1 after an edge with the DUT in FETCH; returns likewise.
  task automatic run_instr(input logic [18:0] word, input int lat,
                           input logic [1:0] j, input logic p, input logic o);
    logic [18:0] a0;
    a0 = imem_addr;
    obs_req_cnt = 0;
    obs_addr_ok = 1'b1;
    for (int i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 19'($urandom);
      jump = 2'($urandom); push = 1'($urandom); pop = 1'($urandom);
      if (imem_req) obs_req_cnt++;
      if (imem_addr !== a0) obs_addr_ok = 1'b0;
      @(posedge clk); #1;
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    if (imem_req) obs_req_cnt++;
    if (imem_addr !== a0) obs_addr_ok = 1'b0;
    @(posedge clk); #1;
    obs_iv      = instr_valid;
    obs_op      = op;
    obs_funct   = funct;
    obs_target  = target;
    obs_pc_exec = pc;
    jump = j; push = p; pop = o;
    imem_valid = 1'b1;
    imem_rdata = 19'($urandom);
    @(posedge clk); #1;
    obs_pc_next   = pc;
    obs_w_pc_next = w_pc;
    obs_iv_after  = instr_valid;
    obs_req_after = imem_req;
    imem_valid = 1'b0;
    jump = 2'($urandom); push = 1'($urandom); pop = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
    n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if (w_pc !== RST_PCW) begin n_err++; $display("FAIL reset_pc_w: got %h want %h", w_pc, RST_PCW); end
    n_cmp++; if ({instr_valid, op, funct, target} !== '0) begin n_err++; $display("FAIL reset_ir: got iv=%b op=%h funct=%h tgt=%h want 0", instr_valid, op, funct, target); end
    n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b%b want 00", stack_overflow, stack_underflow); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_first_fetch: got %b want 1", imem_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(19'h08000, 0, 2'b00, 1'b0, 1'b0);
      model_step(19'h08000, 2'b00, 1'b0, 1'b0);
      n_cmp++; if (obs_iv !== 1'b1) begin n_err++; $display("FAIL zw_iv[%0d]: got %b want 1", i, obs_iv); end
      n_cmp++; if (obs_op !== 5'b00010) begin n_err++; $display("FAIL zw_op[%0d]: got %b want 00010", i, obs_op); end
      n_cmp++; if (obs_pc_exec !== 19'(i)) begin n_err++; $display("FAIL zw_pc[%0d]: got %h want %h", i, obs_pc_exec, 19'(i)); end
      n_cmp++; if (obs_pc_next !== mpc) begin n_err++; $display("FAIL zw_next[%0d]: got %h want %h", i, obs_pc_next, mpc); end
      n_cmp++; if ({obs_iv_after, obs_req_after} !== 2'b01) begin n_err++; $display("FAIL zw_pulse[%0d]: got iv=%b req=%b want iv=0 req=1", i, obs_iv_after, obs_req_after); end
      n_cmp++; if (obs_req_cnt !== 1) begin n_err++; $display("FAIL zw_req_cycles[%0d]: got %0d want 1", i, obs_req_cnt); end
    end
  endtask

  task automatic test_latency();
    logic [18:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w = 19'($urandom);
      run_instr(w, 3, 2'b00, 1'b0, 1'b0);
      model_step(w, 2'b00, 1'b0, 1'b0);
      n_cmp++; if (obs_req_cnt !== 4) begin n_err++; $display("FAIL lat_req_cycles: got %0d want 4", obs_req_cnt); end
      n_cmp++; if (obs_addr_ok !== 1'b1) begin n_err++; $display("FAIL lat_addr_stable: got %b want 1", obs_addr_ok); end
      n_cmp++; if ({obs_iv, obs_op, obs_funct, obs_target} !== {1'b1, w[18:14], w[4:0], 5'b0, w[13:0]})
        begin n_err++; $display("FAIL lat_ir: got iv=%b op=%h funct=%h tgt=%h want word %h", obs_iv, obs_op, obs_funct, obs_target, w); end
      n_cmp++; if (obs_pc_next !== mpc) begin n_err++; $display("FAIL lat_next: got %h want %h", obs_pc_next, mpc); end
    end
  endtask

  task automatic test_call_return();
    do_reset();
    run_instr(19'h00010, 0, 2'b01, 1'b0, 1'b0);
    model_step(19'h00010, 2'b01, 1'b0, 1'b0);
    run_instr(19'h00100, 1, 2'b01, 1'b1, 1'b0);
    model_step(19'h00100, 2'b01, 1'b1, 1'b0);
    n_cmp++; if (obs_pc_exec !== 19'h00010) begin n_err++; $display("FAIL call_pc: got %h want 00010", obs_pc_exec); end
    n_cmp++; if (obs_pc_next !== 19'h00100) begin n_err++; $display("FAIL call_target: got %h want 00100", obs_pc_next); end
    run_instr(19'h0ABCD, 2, 2'b11, 1'b0, 1'b1);
    model_step(19'h0ABCD, 2'b11, 1'b0, 1'b1);
    n_cmp++; if (obs_pc_next !== 19'h00011) begin n_err++; $display("FAIL ret_pc: got %h want 00011", obs_pc_next); end
    run_instr(19'h00000, 0, 2'b00, 1'b1, 1'b1);
    model_step(19'h00000, 2'b00, 1'b1, 1'b1);
    n_cmp++; if (obs_pc_next !== RST_PC) begin n_err++; $display("FAIL pop_empty_pc: got %h want %h", obs_pc_next, RST_PC); end
    n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b01) begin n_err++; $display("FAIL pop_empty_flags: got ovf=%b unf=%b want ovf=0 unf=1", stack_overflow, stack_underflow); end
  endtask

  task automatic test_nested();
    logic [18:0] w;
    logic [18:0] ret_exp;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      w = 19'h00200 + 19'(i * 'h20);
      run_instr(w, i % 2, 2'b01, 1'b1, 1'b0);
      model_step(w, 2'b01, 1'b1, 1'b0);
      n_cmp++; if (obs_pc_next !== w) begin n_err++; $display("FAIL nest_call_pc[%0d]: got %h want %h", i, obs_pc_next, w); end
      n_cmp++; if (stack_overflow !== (i == 8)) begin n_err++; $display("FAIL nest_ovf[%0d]: got %b want %b", i, stack_overflow, (i == 8)); end
    end
    for (int i = 0; i < 9; i++) begin
      ret_exp = (i == 8) ? RST_PC : (i == 7) ? 19'h00001 : 19'h002C1 - 19'(i * 'h20);
      run_instr(19'($urandom), 0, 2'b11, 1'b0, 1'($urandom));
      model_step(19'h0, 2'b11, 1'b0, 1'b0);
      n_cmp++; if (obs_pc_next !== ret_exp || obs_pc_next !== mpc) begin n_err++; $display("FAIL nest_ret_pc[%0d]: got %h want %h", i, obs_pc_next, ret_exp); end
      n_cmp++; if (stack_underflow !== (i == 8)) begin n_err++; $display("FAIL nest_unf[%0d]: got %b want %b", i, stack_underflow, (i == 8)); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(19'h12345, 0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (obs_w_pc_next !== 19'h7FFFF) begin n_err++; $display("FAIL wrap_inc: got %h want 7ffff", obs_w_pc_next); end
    run_instr(19'h12345, 0, 2'b10, 1'b0, 1'b0);
    n_cmp++; if (obs_w_pc_next !== 19'h00000) begin n_err++; $display("FAIL wrap_j10: got %h want 00000", obs_w_pc_next); end
    n_cmp++; if (obs_pc_next !== 19'h00002) begin n_err++; $display("FAIL j10_seq: got %h want 00002", obs_pc_next); end
    do_reset();
    run_instr(19'h00000, 0, 2'b10, 1'b0, 1'b0);
    run_instr(19'h00005, 1, 2'b01, 1'b1, 1'b0);
    n_cmp++; if (obs_w_pc_next !== 19'h00005) begin n_err++; $display("FAIL wrap_call: got %h want 00005", obs_w_pc_next); end
    run_instr(19'h00000, 0, 2'b11, 1'b0, 1'b1);
    n_cmp++; if (obs_w_pc_next !== 19'h00000) begin n_err++; $display("FAIL wrap_ret_addr: got %h want 00000", obs_w_pc_next); end
    run_instr(19'h00000, 0, 2'b11, 1'b0, 1'b0);
    n_cmp++; if (obs_w_pc_next !== RST_PCW || w_unf !== 1'b1) begin n_err++; $display("FAIL wrap_underflow: got pc=%h unf=%b want pc=%h unf=1", obs_w_pc_next, w_unf, RST_PCW); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [18:0] w;
    do_reset();
    imem_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 19'h5ABCD;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    n_cmp++; if ({op, funct, target} !== '0) begin n_err++; $display("FAIL midrst_ir: got op=%h funct=%h tgt=%h want 0", op, funct, target); end
    n_cmp++; if ({instr_valid, imem_req, imem_addr, pc} !== {1'b0, 1'b1, RST_PC, RST_PC})
      begin n_err++; $display("FAIL midrst_restart: got iv=%b req=%b addr=%h pc=%h want iv=0 req=1 addr=pc=%h", instr_valid, imem_req, imem_addr, pc, RST_PC); end
    model_reset();
    w = 19'h2468A;
    run_instr(w, 0, 2'b00, 1'b0, 1'b0);
    n_cmp++; if (obs_pc_exec !== RST_PC || obs_op !== w[18:14]) begin n_err++; $display("FAIL midrst_refetch: got pc=%h op=%h want pc=%h op=%h", obs_pc_exec, obs_op, RST_PC, w[18:14]); end
  endtask

  task automatic test_random();
    logic [18:0] w;
    logic [1:0]  j;
    logic        p, o;
    int          lat;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      w   = 19'($urandom);
      lat = $urandom_range(0, 3);
      j   = 2'($urandom);
      p   = ($urandom_range(0, 9) < 5);
      o   = ($urandom_range(0, 5) == 0);
      run_instr(w, lat, j, p, o);
      n_cmp++; if (obs_pc_exec !== mpc) begin n_err++; $display("FAIL rnd_pc_exec[%0d]: got %h want %h", i, obs_pc_exec, mpc); end
      model_step(w, j, p, o);
      n_cmp++; if ({obs_op, obs_funct, obs_target} !== {w[18:14], w[4:0], 5'b0, w[13:0]})
        begin n_err++; $display("FAIL rnd_fields[%0d]: got op=%h funct=%h tgt=%h want word %h", i, obs_op, obs_funct, obs_target, w); end
      n_cmp++; if (obs_pc_next !== mpc) begin n_err++; $display("FAIL rnd_pc_next[%0d]: got %h want %h (j=%b p=%b o=%b)", i, obs_pc_next, mpc, j, p, o); end
      n_cmp++; if ({stack_overflow, stack_underflow} !== {movf, munf}) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", i, stack_overflow, stack_underflow, movf, munf); end
      n_cmp++; if (obs_req_cnt !== lat + 1) begin n_err++; $display("FAIL rnd_req_cycles[%0d]: got %0d want %0d", i, obs_req_cnt, lat + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_call_return();
    test_nested();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
